// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: parity-mode encodings, the receiver state
// enumeration and the data width. Imported by both ends of the UART so
// transmitter and receiver agree on what each parity_type code means.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    // parity_type encodings; NONE and OFF both mean no parity bit in the frame
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_OFF  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the receiver's serial input, baud enable, parity configuration and
// received-byte outputs.
//   master : drives baud_tick, rx, parity_type; observes the byte outputs
//   slave  : the receiver itself
// Signals:
//   baud_tick    - one-clk enable at OVERSAMPLE x baud rate
//   rx           - asynchronous serial line, idle high
//   parity_type  - 00 none, 01 odd, 10 even, 11 none
//   data_out     - last received byte
//   data_valid   - one-cycle pulse per completed frame
//   parity_error - parity mismatch on the last frame
//   frame_error  - stop bit of the last frame sampled low
//   busy         - receiver is not idle
// -----------------------------------------------------------------------------
interface uart_rx_if;

    logic       baud_tick;
    logic       rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    modport master (
        output baud_tick,
        output rx,
        output parity_type,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  baud_tick,
        input  rx,
        input  parity_type,
        output data_out,
        output data_valid,
        output parity_error,
        output frame_error,
        output busy
    );

endinterface

// File: rtl/rx_parity_check.sv
// -----------------------------------------------------------------------------
// rx_parity_check
// Combinational comparison of a received parity bit against the bit the
// transmitter would have generated for the same data and parity mode.
// Ports:
//   data_i    - received data byte
//   ptype_i   - parity mode latched for this frame
//   rx_bit_i  - parity bit as sampled from the line
//   par_bad_o - 1 when the received bit differs from the expected one
// -----------------------------------------------------------------------------
module rx_parity_check
    import uart_pkg::*;
(
    input  logic [DATA_BITS-1:0] data_i,
    input  logic [1:0]           ptype_i,
    input  logic                 rx_bit_i,
    output logic                 par_bad_o
);

    logic expected_bit;

    // The transmitter's odd-parity generator emits 0 for an all-zero byte
    // rather than the textbook 1; mirror that so the pair interoperates.
    always_comb begin
        expected_bit = 1'b0;
        par_bad_o    = 1'b0;
        if (ptype_i == PARITY_EVEN) begin
            expected_bit = ^data_i;
            par_bad_o    = rx_bit_i ^ expected_bit;
        end else if (ptype_i == PARITY_ODD) begin
            expected_bit = (data_i == '0) ? 1'b0 : ~^data_i;
            par_bad_o    = rx_bit_i ^ expected_bit;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive path. Synchronizes rx, detects start bits with an oversampling
// counter driven by baud_tick, shifts in 8 data bits LSB-first, checks the
// optional parity bit and the stop bit, and presents each byte with a
// one-cycle data_valid pulse plus parity/frame error flags.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - uart_rx_if.slave (baud_tick, rx, parity_type in; byte, flags out)
// Parameters:
//   OVERSAMPLE - baud_tick pulses per bit period (even, >= 4)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int             CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  MID     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  CNT_END = CW'(OVERSAMPLE - 1);

    rx_state_e              state_q;
    logic                   sync1_q;
    logic                   rx_s_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [2:0]             idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [1:0]             ptype_q;
    logic                   par_bad_q;
    logic                   par_bad;
    logic [DATA_BITS-1:0]   data_out_q;
    logic                   data_valid_q;
    logic                   parity_error_q;
    logic                   frame_error_q;

    // Incremented counter and the shift register with the current line value
    // inserted at the active bit position.
    always_comb begin
        cnt_d          = cnt_q + CW'(1);
        shift_d        = shift_q;
        shift_d[idx_q] = rx_s_q;
    end

    rx_parity_check u_parity (
        .data_i    (shift_q),
        .ptype_i   (ptype_q),
        .rx_bit_i  (rx_s_q),
        .par_bad_o (par_bad)
    );

    // Synchronizer, sample counter, deserializer and frame FSM. Everything
    // except the WAIT_IDLE exit advances only on baud_tick so a stalled tick
    // freezes the receiver. The start check happens at mid-bit; subsequent
    // samples are one full bit period apart, keeping every sample centred.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            rx_s_q         <= 1'b1;
            cnt_q          <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            ptype_q        <= PARITY_NONE;
            par_bad_q      <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            sync1_q      <= bus.rx;
            rx_s_q       <= sync1_q;
            data_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.baud_tick && !rx_s_q) begin
                        state_q   <= START;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        par_bad_q <= 1'b0;
                        ptype_q   <= bus.parity_type;
                    end
                end

                START: begin
                    if (bus.baud_tick) begin
                        if (cnt_q == MID) begin
                            cnt_q   <= '0;
                            state_q <= rx_s_q ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                DATA: begin
                    if (bus.baud_tick) begin
                        if (cnt_q == CNT_END) begin
                            cnt_q   <= '0;
                            shift_q <= shift_d;
                            idx_q   <= idx_q + 3'd1;
                            if (idx_q == 3'd7) begin
                                if (ptype_q == PARITY_ODD || ptype_q == PARITY_EVEN) begin
                                    state_q <= PARITY;
                                end else begin
                                    state_q <= STOP;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                PARITY: begin
                    if (bus.baud_tick) begin
                        if (cnt_q == CNT_END) begin
                            cnt_q     <= '0;
                            par_bad_q <= par_bad;
                            state_q   <= STOP;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                // Leaving at mid-stop lets a back-to-back start bit be caught.
                STOP: begin
                    if (bus.baud_tick) begin
                        if (cnt_q == CNT_END) begin
                            cnt_q          <= '0;
                            data_out_q     <= shift_q;
                            parity_error_q <= par_bad_q;
                            frame_error_q  <= ~rx_s_q;
                            data_valid_q   <= 1'b1;
                            state_q        <= rx_s_q ? IDLE : WAIT_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                // A line held low after a bad stop bit must not retrigger.
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx. Drives serial frames bit by bit on a
// 4-clock baud_tick grid (OVERSAMPLE=16) and checks byte, flags, pulse count
// and busy against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   tick_count;
    int   dv_count;
    logic [7:0] dv_log [$];

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud_tick every 4 clocks, counted so stimulus can wait in ticks
    initial begin
        bus.baud_tick = 1'b0;
        tick_count    = 0;
        forever begin
            repeat (3) @(posedge clk);
            #1 bus.baud_tick = 1'b1;
            tick_count++;
            @(posedge clk);
            #1 bus.baud_tick = 1'b0;
        end
    end

    // Record every data_valid cycle; a stuck-high pulse inflates the count
    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_count++;
            dv_log.push_back(bus.data_out);
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one frame; the line is left at the stop-bit value afterwards.
    task automatic send_frame(input logic [7:0] data, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        bus.rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            wait_ticks(OS);
        end
        if (has_par) begin
            bus.rx = par_bit;
            wait_ticks(OS);
        end
        bus.rx = stop_bit;
        wait_ticks(OS);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.parity_type = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.parity_error !== 1'b0 ||
            bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got data=%h dv=%b pe=%b fe=%b busy=%b, want 00 0 0 0 0",
                     bus.data_out, bus.data_valid, bus.parity_error, bus.frame_error, bus.busy);
        end
        rst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_no_parity();
        int base;
        base = dv_count;
        bus.parity_type = 2'b00;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'hA5 || bus.parity_error !== 1'b0 ||
            bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL none_A5: got pulses=%0d data=%h pe=%b fe=%b busy=%b, want 1 a5 0 0 0",
                     dv_count - base, bus.data_out, bus.parity_error, bus.frame_error, bus.busy);
        end
        // parity_type 11 also means no parity bit in the frame
        base = dv_count;
        bus.parity_type = 2'b11;
        send_frame(8'h5E, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h5E || bus.parity_error !== 1'b0 ||
            bus.frame_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL off_5E: got pulses=%0d data=%h pe=%b fe=%b, want 1 5e 0 0",
                     dv_count - base, bus.data_out, bus.parity_error, bus.frame_error);
        end
    endtask

    task automatic test_even_parity();
        int base;
        bus.parity_type = 2'b10;
        base = dv_count;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'hA5 || bus.parity_error !== 1'b1 ||
            bus.frame_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL even_A5_bad: got pulses=%0d data=%h pe=%b fe=%b, want 1 a5 1 0",
                     dv_count - base, bus.data_out, bus.parity_error, bus.frame_error);
        end
        base = dv_count;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h01 || bus.parity_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL even_01_good: got pulses=%0d data=%h pe=%b, want 1 01 0",
                     dv_count - base, bus.data_out, bus.parity_error);
        end
    endtask

    task automatic test_odd_parity();
        int base;
        bus.parity_type = 2'b01;
        base = dv_count;
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h00 || bus.parity_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL odd_00_p0: got pulses=%0d data=%h pe=%b, want 1 00 0",
                     dv_count - base, bus.data_out, bus.parity_error);
        end
        base = dv_count;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.parity_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL odd_00_p1: got pulses=%0d pe=%b, want 1 1",
                     dv_count - base, bus.parity_error);
        end
        // parity_type changed mid-frame must not affect this frame
        base = dv_count;
        fork
            send_frame(8'h07, 1'b1, 1'b0, 1'b1);
            begin
                wait_ticks(3 * OS);
                bus.parity_type = 2'b00;
            end
        join
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h07 || bus.parity_error !== 1'b0 ||
            bus.frame_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL odd_07_p0: got pulses=%0d data=%h pe=%b fe=%b, want 1 07 0 0",
                     dv_count - base, bus.data_out, bus.parity_error, bus.frame_error);
        end
    endtask

    task automatic test_frame_error();
        int base;
        bus.parity_type = 2'b00;
        base = dv_count;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        wait_ticks(3 * OS);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h81 || bus.frame_error !== 1'b1 ||
            bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_held: got pulses=%0d data=%h fe=%b busy=%b, want 1 81 1 1",
                     dv_count - base, bus.data_out, bus.frame_error, bus.busy);
        end
        bus.rx = 1'b1;
        wait_ticks(4);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_release_busy: got %b, want 0", bus.busy);
        end
        base = dv_count;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'h3C || bus.frame_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_break_3C: got pulses=%0d data=%h fe=%b, want 1 3c 0",
                     dv_count - base, bus.data_out, bus.frame_error);
        end
    endtask

    task automatic test_glitch();
        int  base;
        logic saw_busy;
        base = dv_count;
        saw_busy = 1'b0;
        bus.rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ticks(1);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
        end
        bus.rx = 1'b1;
        wait_ticks(6);
        checks++;
        if (saw_busy !== 1'b1 || bus.busy !== 1'b0 || dv_count !== base) begin
            errors++;
            $display("[TB] FAIL glitch: got saw_busy=%b busy=%b pulses=%0d, want 1 0 0",
                     saw_busy, bus.busy, dv_count - base);
        end
        wait_ticks(2 * OS);
        checks++;
        if (dv_count !== base) begin
            errors++;
            $display("[TB] FAIL glitch_late_pulse: got pulses=%0d, want 0", dv_count - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bus.parity_type = 2'b00;
        base = dv_count;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d pulses, want 2", dv_count - base);
        end else begin
            checks++;
            if (dv_log[dv_log.size() - 2] !== 8'h55 || dv_log[dv_log.size() - 1] !== 8'hAA) begin
                errors++;
                $display("[TB] FAIL b2b_data: got %h %h, want 55 aa",
                         dv_log[dv_log.size() - 2], dv_log[dv_log.size() - 1]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        logic [7:0] partial;
        partial = 8'hC3;
        base = dv_count;
        bus.rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            bus.rx = partial[i];
            wait_ticks(OS);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 || bus.parity_error !== 1'b0 ||
            bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got data=%h dv=%b pe=%b fe=%b busy=%b, want 00 0 0 0 0",
                     bus.data_out, bus.data_valid, bus.parity_error, bus.frame_error, bus.busy);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(12 * OS);
        checks++;
        if (dv_count !== base || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_no_pulse: got pulses=%0d busy=%b, want 0 0",
                     dv_count - base, bus.busy);
        end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dv_count - base !== 1 || bus.data_out !== 8'hC3 || bus.frame_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_C3: got pulses=%0d data=%h fe=%b, want 1 c3 0",
                     dv_count - base, bus.data_out, bus.frame_error);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        dv_count = 0;
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
